// File: rtl/bus_arbiter_mux_if.sv
// Datapath bus bundle for bus_arbiter_mux: source requests and data in,
// registered bus value, grant and conflict status out.
interface bus_arbiter_mux_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
);
    // Requests and source data (driven by the control FSM / register file)
    logic [NREG-1:0]       Rout;
    logic                  Gout;
    logic                  DINout;
    logic [WIDTH-1:0]      DIN;
    logic [WIDTH-1:0]      G;
    logic [NREG*WIDTH-1:0] Rdata;
    logic                  ClrErr;

    // Registered bus and status (driven by the arbiter)
    logic [WIDTH-1:0]      Bus;
    logic                  BusValid;
    logic [NREG+1:0]       Grant;
    logic                  Conflict;
    logic [7:0]            ConflictCount;

    modport master (
        output Rout, Gout, DINout, DIN, G, Rdata, ClrErr,
        input  Bus, BusValid, Grant, Conflict, ConflictCount
    );

    modport slave (
        input  Rout, Gout, DINout, DIN, G, Rdata, ClrErr,
        output Bus, BusValid, Grant, Conflict, ConflictCount
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with DIN > G > register priority, fixed-priority
// or round-robin arbitration among registers, and sticky conflict tracking.
module bus_arbiter_mux #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int MODE  = 0
) (
    input  logic             Clock,
    input  logic             Resetn,
    bus_arbiter_mux_if.slave bif
);
    localparam int            PW     = $clog2(NREG);
    localparam int            GW     = NREG + 2;
    localparam logic [PW:0]   NREG_W = (PW+1)'(NREG);

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic             conflict_q, conflict_d;
    logic [7:0]       count_q, count_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [NREG-1:0]  req_r;      // req_r[i] is the request of register Ri
    logic             reg_hit;
    logic [PW-1:0]    reg_idx;
    logic [PW:0]      scan_sum;
    logic [WIDTH-1:0] reg_data;
    logic [NREG-1:0]  reg_grant;
    logic [PW-1:0]    ptr_next;
    logic             multi_req;

    // Reorder requests so that index i means register Ri (Rout is MSB-first).
    always_comb begin
        req_r = '0;
        for (int i = 0; i < NREG; i++) begin
            req_r[i] = bif.Rout[NREG-1-i];
        end
    end

    // Scan registers starting at 0 (fixed) or at ptr (round-robin), wrapping mod NREG.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        reg_hit  = 1'b0;
        reg_idx  = '0;
        scan_sum = '0;
        for (int off = 0; off < NREG; off++) begin
            scan_sum = (PW+1)'(off);
            if (MODE == 1) begin
                scan_sum = scan_sum + {1'b0, ptr_q};
            end
            if (scan_sum >= NREG_W) begin
                scan_sum = scan_sum - NREG_W;
            end
            if (!reg_hit && req_r[scan_sum[PW-1:0]]) begin
                reg_hit = 1'b1;
                reg_idx = scan_sum[PW-1:0];
            end
        end
    end

    // Data and one-hot grant of the winning register; pointer value after it.
    always_comb begin
        reg_data  = '0;
        reg_grant = '0;
        for (int i = 0; i < NREG; i++) begin
            if (reg_idx == PW'(i)) begin
                reg_data            = bif.Rdata[i*WIDTH +: WIDTH];
                reg_grant[NREG-1-i] = 1'b1;
            end
        end
        ptr_next = (({1'b0, reg_idx} + (PW+1)'(1)) == NREG_W) ? '0 : reg_idx + 1'b1;
    end

    assign multi_req = $countones({bif.DINout, bif.Gout, bif.Rout}) > 1;

    // Next-state: winner selection, bus hold on idle, conflict sticky/saturating count.
    always_comb begin
        bus_d      = bus_q;
        valid_d    = 1'b0;
        grant_d    = '0;
        ptr_d      = ptr_q;
        conflict_d = conflict_q;
        count_d    = count_q;

        if (bif.DINout) begin
            bus_d         = bif.DIN;
            grant_d[GW-1] = 1'b1;
            valid_d       = 1'b1;
        end else if (bif.Gout) begin
            bus_d         = bif.G;
            grant_d[GW-2] = 1'b1;
            valid_d       = 1'b1;
        end else if (reg_hit) begin
            bus_d              = reg_data;
            grant_d[NREG-1:0]  = reg_grant;
            valid_d            = 1'b1;
            if (MODE == 1) begin
                ptr_d = ptr_next;
            end
        end

        // A conflict in the same cycle as a clear restarts the count at one.
        if (multi_req) begin
            conflict_d = 1'b1;
            if (bif.ClrErr) begin
                count_d = 8'd1;
            end else if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (bif.ClrErr) begin
            conflict_d = 1'b0;
            count_d    = 8'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bus_q      <= '0;
            valid_q    <= 1'b0;
            grant_q    <= '0;
            conflict_q <= 1'b0;
            count_q    <= 8'd0;
            ptr_q      <= '0;
        end else begin
            bus_q      <= bus_d;
            valid_q    <= valid_d;
            grant_q    <= grant_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bif.Bus           = bus_q;
    assign bif.BusValid      = valid_q;
    assign bif.Grant         = grant_q;
    assign bif.Conflict      = conflict_q;
    assign bif.ConflictCount = count_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench: three arbiters (NREG=8 fixed, NREG=8 round-robin,
// NREG=5 round-robin) see the same stimulus; a behavioural model pushes the
// expected outputs each cycle and they are popped and compared after the edge.
module tb_bus_arbiter_mux;
    typedef struct packed {
        logic [15:0] bus;
        logic        valid;
        logic [9:0]  grant;
        logic        conf;
        logic [7:0]  cnt;
        logic [3:0]  ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]   rout8;
    logic         gout, dinout, clr;
    logic [15:0]  din, g;
    logic [15:0]  rv [8];
    logic [127:0] rdata8;

    int   n_checks = 0;
    int   n_bad    = 0;
    exp_t m [3];
    exp_t sb [$];

    bus_arbiter_mux_if #(.WIDTH(16), .NREG(8)) if0 ();
    bus_arbiter_mux_if #(.WIDTH(16), .NREG(8)) if1 ();
    bus_arbiter_mux_if #(.WIDTH(16), .NREG(5)) if2 ();

    assign if0.Rout = rout8;        assign if1.Rout = rout8;        assign if2.Rout = rout8[4:0];
    assign if0.Gout = gout;         assign if1.Gout = gout;         assign if2.Gout = gout;
    assign if0.DINout = dinout;     assign if1.DINout = dinout;     assign if2.DINout = dinout;
    assign if0.DIN = din;           assign if1.DIN = din;           assign if2.DIN = din;
    assign if0.G = g;               assign if1.G = g;               assign if2.G = g;
    assign if0.Rdata = rdata8;      assign if1.Rdata = rdata8;      assign if2.Rdata = rdata8[79:0];
    assign if0.ClrErr = clr;        assign if1.ClrErr = clr;        assign if2.ClrErr = clr;

    bus_arbiter_mux #(.WIDTH(16), .NREG(8), .MODE(0)) u0 (.Clock(clk), .Resetn(rst_n), .bif(if0));
    bus_arbiter_mux #(.WIDTH(16), .NREG(8), .MODE(1)) u1 (.Clock(clk), .Resetn(rst_n), .bif(if1));
    bus_arbiter_mux #(.WIDTH(16), .NREG(5), .MODE(1)) u2 (.Clock(clk), .Resetn(rst_n), .bif(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model of one arbiter for the current inputs.
    task automatic model_step(input int k, input int nreg, input int mode);
        int n;
        int win;
        n = int'(dinout) + int'(gout);
        for (int j = 0; j < nreg; j++) n += int'(rout8[j]);
        win = -1;
        m[k].grant = '0;
        m[k].valid = 1'b0;
        if (dinout) begin
            m[k].bus = din;  m[k].grant[nreg+1] = 1'b1;  m[k].valid = 1'b1;
        end else if (gout) begin
            m[k].bus = g;    m[k].grant[nreg] = 1'b1;    m[k].valid = 1'b1;
        end else begin
            for (int j = 0; j < nreg; j++) begin
                int i;
                i = (mode == 1) ? (int'(m[k].ptr) + j) % nreg : j;
                if (win < 0 && rout8[nreg-1-i]) win = i;
            end
            if (win >= 0) begin
                m[k].bus = rv[win];
                m[k].grant[nreg-1-win] = 1'b1;
                m[k].valid = 1'b1;
                if (mode == 1) m[k].ptr = 4'((win + 1) % nreg);
            end
        end
        if (n > 1) begin
            m[k].conf = 1'b1;
            if (clr)                  m[k].cnt = 8'd1;
            else if (m[k].cnt != 8'hFF) m[k].cnt = m[k].cnt + 8'd1;
        end else if (clr) begin
            m[k].conf = 1'b0;
            m[k].cnt  = 8'd0;
        end
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [15:0] bus, input logic valid,
                       input logic [9:0] grant, input logic conf, input logic [7:0] cnt);
        check({nm, ".bus"},   32'(bus),   32'(e.bus));
        check({nm, ".valid"}, 32'(valid), 32'(e.valid));
        check({nm, ".grant"}, 32'(grant), 32'(e.grant));
        check({nm, ".conf"},  32'(conf),  32'(e.conf));
        check({nm, ".cnt"},   32'(cnt),   32'(e.cnt));
    endtask

    // One arbitration cycle: predict, clock, pop and compare.
    task automatic step();
        exp_t e;
        model_step(0, 8, 0);
        model_step(1, 8, 1);
        model_step(2, 5, 1);
        sb.push_back(m[0]);
        sb.push_back(m[1]);
        sb.push_back(m[2]);
        @(posedge clk);
        #2;
        e = sb.pop_front();
        cmp("u0", e, if0.Bus, if0.BusValid, if0.Grant, if0.Conflict, if0.ConflictCount);
        e = sb.pop_front();
        cmp("u1", e, if1.Bus, if1.BusValid, if1.Grant, if1.Conflict, if1.ConflictCount);
        e = sb.pop_front();
        cmp("u2", e, if2.Bus, if2.BusValid, {3'b000, if2.Grant}, if2.Conflict, if2.ConflictCount);
    endtask

    task automatic idle_inputs();
        rout8 = '0; gout = 1'b0; dinout = 1'b0; clr = 1'b0;
    endtask

    task automatic check_reset_state(input string nm, input logic [15:0] bus, input logic valid,
                                     input logic [9:0] grant, input logic conf, input logic [7:0] cnt);
        check({nm, ".rst_bus"},   32'(bus),   32'h0);
        check({nm, ".rst_valid"}, 32'(valid), 32'h0);
        check({nm, ".rst_grant"}, 32'(grant), 32'h0);
        check({nm, ".rst_conf"},  32'(conf),  32'h0);
        check({nm, ".rst_cnt"},   32'(cnt),   32'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rv[i] = 16'hA000 | 16'(i * 16'h0111);
            rdata8[i*16 +: 16] = rv[i];
        end
        idle_inputs();
        din = 16'h0; g = 16'h0;
        for (int k = 0; k < 3; k++) m[k] = '0;

        // Reset state
        rst_n = 1'b0;
        #12;
        check_reset_state("u0", if0.Bus, if0.BusValid, if0.Grant, if0.Conflict, if0.ConflictCount);
        check_reset_state("u2", if2.Bus, if2.BusValid, {3'b000, if2.Grant}, if2.Conflict, if2.ConflictCount);
        rst_n = 1'b1;

        // Priority: DIN beats G and registers; conflict flagged
        dinout = 1'b1; gout = 1'b1; rout8 = 8'b1000_0000; din = 16'h1234;
        step();
        check("prio.bus",   32'(if0.Bus),           32'h1234);
        check("prio.grant", 32'(if0.Grant),         32'h200);
        check("prio.cnt",   32'(if0.ConflictCount), 32'd1);

        // Hold: grant G, then three idle cycles with G changing
        idle_inputs(); gout = 1'b1; g = 16'h00A5;
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            g = 16'h5A00 + 16'(c);
            step();
            check("hold.bus",   32'(if0.Bus),      32'h00A5);
            check("hold.valid", 32'(if0.BusValid), 32'h0);
        end

        // Clear alone, then R0/R2/R7 held four cycles
        clr = 1'b1;
        step();
        idle_inputs(); rout8 = 8'b1010_0001;
        for (int c = 0; c < 4; c++) begin
            logic [9:0] rr_exp [4];
            rr_exp = '{10'h080, 10'h020, 10'h001, 10'h080};
            step();
            check("rr.grant",  32'(if1.Grant), 32'(rr_exp[c]));
            check("fix.grant", 32'(if0.Grant), 32'h080);
        end
        check("rr.cnt", 32'(if1.ConflictCount), 32'd4);

        // NREG=5 round-robin wrap: R0/R3/R4 for u2
        rout8 = 8'b0001_0011;
        for (int c = 0; c < 5; c++) step();

        // Saturation and clear
        idle_inputs(); dinout = 1'b1; gout = 1'b1; din = 16'h0F0F;
        for (int c = 0; c < 300; c++) step();
        check("sat.cnt", 32'(if0.ConflictCount), 32'd255);
        idle_inputs(); clr = 1'b1;
        step();
        check("clr.conf", 32'(if0.Conflict),      32'h0);
        check("clr.cnt",  32'(if0.ConflictCount), 32'h0);
        dinout = 1'b1; gout = 1'b1;
        step();
        check("clrc.conf", 32'(if0.Conflict),      32'h1);
        check("clrc.cnt",  32'(if0.ConflictCount), 32'h1);

        // Random traffic
        for (int c = 0; c < 60; c++) begin
            rout8  = 8'($urandom);
            gout   = ($urandom_range(0, 5) == 0);
            dinout = ($urandom_range(0, 5) == 0);
            clr    = ($urandom_range(0, 7) == 0);
            din    = 16'($urandom);
            g      = 16'($urandom);
            step();
        end

        // Reset mid-operation, pointer restarts at R0
        idle_inputs(); rout8 = 8'b1010_0001;
        step();
        idle_inputs(); dinout = 1'b1; din = 16'hBEEF;
        step();
        check("pre_rst.bus", 32'(if0.Bus), 32'hBEEF);
        #1 rst_n = 1'b0;
        #1;
        check_reset_state("u0", if0.Bus, if0.BusValid, if0.Grant, if0.Conflict, if0.ConflictCount);
        check_reset_state("u1", if1.Bus, if1.BusValid, if1.Grant, if1.Conflict, if1.ConflictCount);
        for (int k = 0; k < 3; k++) m[k] = '0;
        #1 rst_n = 1'b1;
        idle_inputs(); rout8 = 8'b1010_0001;
        step();
        check("post_rst.grant", 32'(if1.Grant), 32'h080);
        step();
        check("post_rst.grant2", 32'(if1.Grant), 32'h020);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
